phy_rcv_deframer: RTL and testbench
===================================

// Module: phy_rcv_deframer
// PURPOSE
// - Receive-side counterpart of the xmit path: samples the 4-bit PHY nibble stream (phy_data_in/phy_rx_dv),
//   strips preamble/SFD, reassembles bytes and emits them with a per-frame 24-bit control block.
// - Sits between the PHY pins and the receive FIFO/frame buffer, in the clk_phy domain.
// PARAMETERS
// - MIN_LEN   64    minimum legal frame length in bytes (post-SFD); shorter -> runt error
// - MAX_LEN   2047  maximum legal frame length in bytes; byte MAX_LEN+1 onward is dropped, giant error
// - PRE_MIN   7     minimum count of 0x5 preamble nibbles required before the SFD nibble 0xD
// PORTS
// - clk_phy          in   1   PHY clock; all logic on rising edge
// - reset_n          in   1   asynchronous active-low reset
// - phy_data_in      in   4   receive nibble, low nibble of each byte first
// - phy_rx_dv        in   1   receive data valid; frame spans one contiguous high interval
// - r_data_out       out  8   reassembled byte
// - r_data_valid     out  1   1-cycle strobe, r_data_out valid
// - r_ctrl_out       out  24  {total_len[11:0], delivered_len[11:0]}; held until next frame end
// - r_frame_valid    out  1   1-cycle strobe at frame end, r_ctrl_out/r_frame_err valid
// - r_frame_err      out  1   frame-end status: runt, giant, odd nibble, bad preamble (or CRC if enabled)
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, state IDLE, counters 0.
// - States: IDLE -> PRE on phy_rx_dv=1 & nibble 0x5; PRE counts 0x5 nibbles; 0xD with count>=PRE_MIN -> DATA;
//   any other nibble in PRE, or 0xD with count<PRE_MIN -> DROP; DATA -> END when phy_rx_dv falls;
//   DROP -> END when phy_rx_dv falls; END -> IDLE next cycle. phy_rx_dv=1 with non-0x5 in IDLE -> DROP.
// - DATA: nibble phase toggles each cycle; phase0 latches low nibble, phase1 forms {in,low}.
//   r_data_valid pulses the cycle after the phase1 nibble is sampled (latency 1 clk); max rate 1 byte / 2 clk.
// - total_len counts every assembled byte in the frame, saturating at 12'hFFF.
//   delivered_len counts bytes actually strobed out; delivery stops after MAX_LEN bytes.
// - END cycle: r_frame_valid=1 for exactly one clk, r_ctrl_out updated the same cycle;
//   r_frame_err=1 if total_len<MIN_LEN, total_len>MAX_LEN, odd nibble count (dangling low nibble is
//   discarded, not delivered), or entered via DROP. Good 512-byte frame -> r_ctrl_out=24'h200200, err=0.
// - DROP frames: no r_data_valid; r_frame_valid still pulses with err=1, r_ctrl_out=24'h000000.
// - phy_rx_dv low for one cycle ends the frame; re-assertion in the END cycle is treated as IDLE input
//   next cycle (that nibble is lost and the frame goes to DROP: preamble too short).
// - phy_rx_dv held high with no SFD: stays in PRE, no outputs until phy_rx_dv falls (then err frame).
// - reset_n asserted mid-frame: immediate IDLE, no r_frame_valid for the aborted frame; after release the
//   remainder of that frame (phy_rx_dv still high, non-0x5 data) is handled as DROP.
// - r_data_valid and r_frame_valid never assert in the same cycle.
// CONFIGURATION
// - PHY_RCV_CRC_CHECK_EN defined: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over all
//   delivered bytes; at END residue != 0xC704DD7B sets r_frame_err. Last 4 bytes (FCS) still delivered
//   and counted. Frames >MAX_LEN skip the check (already error).
// - Not defined: no CRC logic; r_frame_err covers only framing/length errors.
// TESTING
// - Reset: reset_n=0 with phy_rx_dv toggling -> all outputs stay 0; release -> IDLE, no strobes.
// - 7x0x5, 0xD, 512 bytes 0xAA (nibbles A,A), dv falls -> 512 r_data_valid strobes of 8'hAA spaced 2 clk,
//   then r_frame_valid with r_ctrl_out=24'h200200, r_frame_err=0.
// - 32-byte frame 0x11 -> 32 strobes, r_ctrl_out=24'h020020, r_frame_err=1 (runt).
// - 2100-byte frame 0x55 -> 2047 strobes, r_ctrl_out=24'h8347FF, r_frame_err=1 (giant).
// - 5x0x5 then 0xD then 100 bytes -> no r_data_valid; r_frame_valid with err=1, ctrl=24'h000000;
//   odd-nibble 64-byte frame (129 nibbles) -> 64 strobes, ctrl=24'h040040, err=1.
// - Back-to-back frames 1-clk gap and reset_n pulse mid-frame -> second frame lost per END/reset rules;
//   with PHY_RCV_CRC_CHECK_EN: valid-FCS 64-byte frame err=0, one flipped payload bit err=1.

Source files
------------

// File: rtl/phy_rcv_deframer.sv
// Receive deframer: strips preamble/SFD from the PHY nibble stream, rebuilds bytes, reports per-frame length/status.
// Optional CRC-32 frame check is compiled in with `define PHY_RCV_CRC_CHECK_EN.
module phy_rcv_deframer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 2047,
  parameter int PRE_MIN = 7
) (
  input  logic        clk_phy,
  input  logic        reset_n,
  input  logic [3:0]  phy_data_in,
  input  logic        phy_rx_dv,
  output logic [7:0]  r_data_out,
  output logic        r_data_valid,
  output logic [23:0] r_ctrl_out,
  output logic        r_frame_valid,
  output logic        r_frame_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_DROP = 3'd3;
  localparam logic [2:0] ST_END  = 3'd4;

  localparam logic [11:0] MIN_L = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  localparam logic [3:0]  PRE_L = 4'(PRE_MIN);

  logic [2:0]  state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  low_q, low_d;
  logic [11:0] total_q, total_d;
  logic [11:0] deliv_q, deliv_d;
  logic [7:0]  data_q, data_d;
  logic        data_vld_q, data_vld_d;
  logic [23:0] ctrl_q, ctrl_d;
  logic        frm_vld_q, frm_vld_d;
  logic        frm_err_q, frm_err_d;
  logic [7:0]  byte_w;
  logic        crc_bad;

`ifdef PHY_RCV_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Register is kept reflected, so the good-frame residue is compared bit-reversed.
  assign crc_bad = (total_q <= MAX_L) && (bit_rev(crc_q) != 32'hC704DD7B);
`else
  assign crc_bad = 1'b0;
`endif

  assign byte_w = {phy_data_in, low_q};

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    phase_d    = phase_q;
    low_d      = low_q;
    total_d    = total_q;
    deliv_d    = deliv_q;
    data_d     = data_q;
    data_vld_d = 1'b0;
    ctrl_d     = ctrl_q;
    frm_vld_d  = 1'b0;
    frm_err_d  = frm_err_q;
`ifdef PHY_RCV_CRC_CHECK_EN
    crc_d      = crc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        total_d   = 12'd0;
        deliv_d   = 12'd0;
        phase_d   = 1'b0;
        pre_cnt_d = 4'd0;
`ifdef PHY_RCV_CRC_CHECK_EN
        crc_d     = 32'hFFFFFFFF;
`endif
        if (phy_rx_dv) begin
          if (phy_data_in == 4'h5) begin
            state_d   = ST_PRE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_PRE: begin
        if (!phy_rx_dv) begin
          state_d   = ST_END;
          frm_vld_d = 1'b1;
          frm_err_d = 1'b1;
          ctrl_d    = 24'h000000;
        end else if (phy_data_in == 4'h5) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (phy_data_in == 4'hD && pre_cnt_q >= PRE_L) begin
          state_d = ST_DATA;
          phase_d = 1'b0;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!phy_rx_dv) begin
          // A dangling low nibble (phase still 1) is simply never assembled.
          state_d   = ST_END;
          frm_vld_d = 1'b1;
          ctrl_d    = {total_q, deliv_q};
          frm_err_d = (total_q < MIN_L) || (total_q > MAX_L) || phase_q || crc_bad;
        end else if (!phase_q) begin
          low_d   = phy_data_in;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          total_d = (total_q == 12'hFFF) ? total_q : total_q + 12'd1;
          if (deliv_q < MAX_L) begin
            data_d     = byte_w;
            data_vld_d = 1'b1;
            deliv_d    = deliv_q + 12'd1;
`ifdef PHY_RCV_CRC_CHECK_EN
            crc_d      = crc_step(crc_q, byte_w);
`endif
          end
        end
      end
      ST_DROP: begin
        if (!phy_rx_dv) begin
          state_d   = ST_END;
          frm_vld_d = 1'b1;
          frm_err_d = 1'b1;
          ctrl_d    = 24'h000000;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pre_cnt_q  <= 4'd0;
      phase_q    <= 1'b0;
      low_q      <= 4'd0;
      total_q    <= 12'd0;
      deliv_q    <= 12'd0;
      data_q     <= 8'd0;
      data_vld_q <= 1'b0;
      ctrl_q     <= 24'd0;
      frm_vld_q  <= 1'b0;
      frm_err_q  <= 1'b0;
`ifdef PHY_RCV_CRC_CHECK_EN
      crc_q      <= 32'hFFFFFFFF;
`endif
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
      total_q    <= total_d;
      deliv_q    <= deliv_d;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
      ctrl_q     <= ctrl_d;
      frm_vld_q  <= frm_vld_d;
      frm_err_q  <= frm_err_d;
`ifdef PHY_RCV_CRC_CHECK_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign r_data_out    = data_q;
  assign r_data_valid  = data_vld_q;
  assign r_ctrl_out    = ctrl_q;
  assign r_frame_valid = frm_vld_q;
  assign r_frame_err   = frm_err_q;

endmodule

// File: tb/tb_phy_rcv_deframer.sv
// Randomized + directed bench for phy_rcv_deframer against a frame-level reference model.
module tb_phy_rcv_deframer;
  logic        clk_phy = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  phy_data_in = 4'h0;
  logic        phy_rx_dv = 1'b0;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic [23:0] r_ctrl_out;
  logic        r_frame_valid;
  logic        r_frame_err;

  always #5 clk_phy = ~clk_phy;

  phy_rcv_deframer dut (
    .clk_phy(clk_phy), .reset_n(reset_n), .phy_data_in(phy_data_in), .phy_rx_dv(phy_rx_dv),
    .r_data_out(r_data_out), .r_data_valid(r_data_valid), .r_ctrl_out(r_ctrl_out),
    .r_frame_valid(r_frame_valid), .r_frame_err(r_frame_err)
  );

  typedef struct packed { logic [23:0] ctrl; logic err; } frm_t;

  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_b[$];
  frm_t       exp_f[$];
  logic [23:0] held_ctrl = 24'd0;
  logic        prev_dv = 1'b0;
  int          strobes = 0;
  logic [23:0] last_ctrl = 24'd0;
  logic        last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle compare against the expectation queues.
  always @(negedge clk_phy) begin : mon
    logic [7:0] e;
    frm_t f;
    if (!reset_n) begin
      check("reset_strobes", 32'({r_data_valid, r_frame_valid, r_frame_err}), 32'd0);
      check("reset_data", 32'(r_data_out), 32'd0);
      check("reset_ctrl", 32'(r_ctrl_out), 32'd0);
      held_ctrl = 24'd0;
      prev_dv = 1'b0;
    end else begin
      check("dv_fv_overlap", 32'(r_data_valid & r_frame_valid), 32'd0);
      if (r_data_valid) begin
        check("byte_spacing", 32'(prev_dv), 32'd0);
        if (exp_b.size() == 0) check("unexpected_byte", 32'(r_data_out), 32'hFFFF_FFFF);
        else begin
          e = exp_b.pop_front();
          check("byte", 32'(r_data_out), 32'(e));
        end
        strobes++;
      end
      if (r_frame_valid) begin
        if (exp_f.size() == 0) check("unexpected_frame", 32'(r_ctrl_out), 32'hFFFF_FFFF);
        else begin
          f = exp_f.pop_front();
          check("frame_ctrl", 32'(r_ctrl_out), 32'(f.ctrl));
          check("frame_err", 32'(r_frame_err), 32'(f.err));
          held_ctrl = f.ctrl;
        end
        last_ctrl = r_ctrl_out;
        last_err  = r_frame_err;
      end else begin
        check("ctrl_held", 32'(r_ctrl_out), 32'(held_ctrl));
      end
      prev_dv = r_data_valid;
    end
  end

  logic [3:0] fq[$];
  logic [7:0] bq[$];
  int last_gap = 8;

  function automatic logic [31:0] crc32(input logic [7:0] d[$], input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ 32'(d[i]);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic fill_bq(input int n, input int fill);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(fill < 0 ? 8'($urandom) : 8'(fill));
  endtask

  task automatic build(input int pre, input logic [3:0] sfd, input bit odd);
    fq.delete();
    repeat (pre) fq.push_back(4'h5);
    fq.push_back(sfd);
    foreach (bq[i]) begin
      fq.push_back(bq[i][3:0]);
      fq.push_back(bq[i][7:4]);
    end
    if (odd) fq.push_back(4'($urandom));
  endtask

  // Frame-level model: preamble = leading 0x5 run, then 0xD, then nibble pairs.
  task automatic model(input int skip);
    int k, n, nb, tot, del;
    bit err;
    logic [7:0] bytes[$];
    frm_t f;
    k = skip;
    while (k < fq.size() && fq[k] == 4'h5) k++;
    if (k == skip || k == fq.size() || fq[k] != 4'hD || (k - skip) < 7) begin
      f.ctrl = 24'h000000; f.err = 1'b1;
    end else begin
      n  = fq.size() - k - 1;
      nb = n / 2;
      for (int i = 0; i < nb; i++) begin
        bytes.push_back({fq[k+2+2*i], fq[k+1+2*i]});
        if (i < 2047) exp_b.push_back({fq[k+2+2*i], fq[k+1+2*i]});
      end
      tot = (nb > 4095) ? 4095 : nb;
      del = (nb > 2047) ? 2047 : nb;
      err = (tot < 64) || (tot > 2047) || (n % 2 != 0);
`ifdef PHY_RCV_CRC_CHECK_EN
      if (tot <= 2047) begin
        if (nb < 4) err = 1'b1;
        else if (crc32(bytes, nb - 4) != {bytes[nb-1], bytes[nb-2], bytes[nb-3], bytes[nb-4]}) err = 1'b1;
      end
`endif
      f.ctrl = {12'(tot), 12'(del)}; f.err = err;
    end
    exp_f.push_back(f);
  endtask

  // A one-cycle gap means the first nibble of the next frame lands in END and is lost.
  task automatic drive(input int gap);
    model(last_gap == 1 ? 1 : 0);
    foreach (fq[i]) begin
      @(posedge clk_phy); #1;
      phy_rx_dv = 1'b1; phy_data_in = fq[i];
    end
    @(posedge clk_phy); #1;
    phy_rx_dv = 1'b0; phy_data_in = 4'($urandom);
    repeat (gap - 1) @(posedge clk_phy);
    last_gap = gap;
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk_phy);
    @(negedge clk_phy);
    check(tag, 32'(exp_b.size() + exp_f.size()), 32'd0);
    last_gap = 8;
  endtask

  int base;

  initial begin
    repeat (6) begin
      @(posedge clk_phy); #1;
      phy_rx_dv = 1'($urandom); phy_data_in = 4'($urandom);
    end
    phy_rx_dv = 1'b0;
    @(posedge clk_phy); #1 reset_n = 1'b1;
    repeat (5) @(posedge clk_phy);
    check("idle_after_reset", 32'(strobes), 32'd0);

    base = strobes;
    fill_bq(512, 8'hAA); build(7, 4'hD, 0); drive(3); drain("drain_512");
    check("pin512_cnt", 32'(strobes - base), 32'd512);
    check("pin512_ctrl", 32'(last_ctrl), 32'h200200);
`ifndef PHY_RCV_CRC_CHECK_EN
    check("pin512_err", 32'(last_err), 32'd0);
`endif

    base = strobes;
    fill_bq(32, 8'h11); build(7, 4'hD, 0); drive(2); drain("drain_runt");
    check("pin_runt_cnt", 32'(strobes - base), 32'd32);
    check("pin_runt_ctrl", 32'(last_ctrl), 32'h020020);
    check("pin_runt_err", 32'(last_err), 32'd1);

    base = strobes;
    fill_bq(2100, 8'h55); build(7, 4'hD, 0); drive(2); drain("drain_giant");
    check("pin_giant_cnt", 32'(strobes - base), 32'd2047);
    check("pin_giant_ctrl", 32'(last_ctrl), 32'h8347FF);
    check("pin_giant_err", 32'(last_err), 32'd1);

    base = strobes;
    fill_bq(100, -1); build(5, 4'hD, 0); drive(2); drain("drain_shortpre");
    check("pin_shortpre_cnt", 32'(strobes - base), 32'd0);
    check("pin_shortpre_ctrl", 32'(last_ctrl), 32'h000000);
    check("pin_shortpre_err", 32'(last_err), 32'd1);

    base = strobes;
    fill_bq(64, 8'h77); build(7, 4'hD, 1); drive(2); drain("drain_odd");
    check("pin_odd_cnt", 32'(strobes - base), 32'd64);
    check("pin_odd_ctrl", 32'(last_ctrl), 32'h040040);
    check("pin_odd_err", 32'(last_err), 32'd1);

    fill_bq(0, 0); build(30, 4'h5, 0); drive(2); drain("drain_nosfd");
    check("pin_nosfd_err", 32'(last_err), 32'd1);

    // Back-to-back with a 1-clk gap: second frame loses a preamble nibble.
    base = strobes;
    fill_bq(64, -1); build(7, 4'hD, 0); drive(1);
    fill_bq(64, -1); build(7, 4'hD, 0); drive(2); drain("drain_b2b");
    check("pin_b2b_cnt", 32'(strobes - base), 32'd64);
    check("pin_b2b_ctrl", 32'(last_ctrl), 32'h000000);
    check("pin_b2b_err", 32'(last_err), 32'd1);

    // Reset mid-frame: bytes before the reset are delivered, no frame strobe for it.
    fill_bq(10, 8'h3C); build(7, 4'hD, 0);
    repeat (10) exp_b.push_back(8'h3C);
    foreach (fq[i]) begin
      @(posedge clk_phy); #1;
      phy_rx_dv = 1'b1; phy_data_in = fq[i];
    end
    @(posedge clk_phy); #1 phy_data_in = 4'hA;
    @(posedge clk_phy); #1 reset_n = 1'b0;
    check("rst_mid_bytes", 32'(exp_b.size()), 32'd0);
    repeat (2) @(posedge clk_phy);
    #1 reset_n = 1'b1;
    fq.delete(); fq.push_back(4'hA);
    repeat (20) fq.push_back(4'($urandom));
    last_gap = 8; drive(2); drain("drain_rst_mid");
    check("pin_rst_ctrl", 32'(last_ctrl), 32'h000000);
    check("pin_rst_err", 32'(last_err), 32'd1);

`ifdef PHY_RCV_CRC_CHECK_EN
    begin
      logic [31:0] fcs;
      fill_bq(60, -1);
      fcs = crc32(bq, 60);
      for (int i = 0; i < 4; i++) bq.push_back(fcs[8*i +: 8]);
      build(7, 4'hD, 0); drive(2); drain("drain_crc_ok");
      check("pin_crc_ok_err", 32'(last_err), 32'd0);
      bq[5] = bq[5] ^ 8'h10;
      build(7, 4'hD, 0); drive(2); drain("drain_crc_bad");
      check("pin_crc_bad_err", 32'(last_err), 32'd1);
    end
`endif

    for (int t = 0; t < 30; t++) begin
      int r, pre;
      logic [3:0] sfd;
      r = $urandom_range(0, 9);
      pre = (r < 6) ? $urandom_range(7, 10) : (r == 6) ? $urandom_range(1, 6) : (r == 7) ? 8 : 0;
      sfd = (r == 7) ? 4'($urandom) : 4'hD;
      fill_bq($urandom_range(20, 150), -1);
      build(pre, sfd, $urandom_range(0, 3) == 0);
      drive($urandom_range(1, 4));
    end
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
